// File: rtl/cve2_mem_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cve2_mem_resp_pkg
// Description : Shared types and address decode helper for the memory
//               responder and its response delay line.
//               Contents:
//                 mem_resp_t   - one response slot (valid / err / rdata)
//                 mem_decode_t - result of the address decode
//                 mem_decode() - byte address -> in_range + word index
// Revision    : 1.0 - initial release
// ============================================================================
package cve2_mem_resp_pkg;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } mem_resp_t;

    typedef struct packed {
        logic        in_range;
        logic [31:0] word_idx;
    } mem_decode_t;

    // The subtraction wraps, so an address below the base turns into a huge
    // offset and falls out of range without a separate lower-bound compare.
    function automatic mem_decode_t mem_decode(input logic [31:0] addr,
                                               input logic [31:0] base,
                                               input logic [31:0] num_words);
        logic [31:0] offset;
        mem_decode_t dec;
        offset       = addr - base;
        dec.in_range = (offset < (num_words << 2));
        dec.word_idx = offset >> 2;
        return dec;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cve2_mem_resp_delay.sv
`default_nettype none
// ============================================================================
// Module      : cve2_mem_resp_delay
// Description : Fixed-depth shift register carrying responses from the grant
//               edge to the response output. Cleared asynchronously so that
//               no in-flight response survives a reset.
//               Ports:
//                 clk_i   in   clock
//                 rst_i   in   asynchronous active-high clear
//                 resp_i  in   response captured at the grant edge
//                 resp_o  out  response after Depth cycles
// Revision    : 1.0 - initial release
// ============================================================================
module cve2_mem_resp_delay
    import cve2_mem_resp_pkg::*;
#(
    parameter int unsigned Depth = 1
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  mem_resp_t resp_i,
    output mem_resp_t resp_o
);

    mem_resp_t [Depth-1:0] r_pipe;

    generate
        if (Depth == 1) begin : g_single
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe[0] <= resp_i;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_pipe <= '0;
                end else begin
                    r_pipe <= {r_pipe[Depth-2:0], resp_i};
                end
            end
        end
    endgenerate

    assign resp_o = r_pipe[Depth-1];

endmodule
`default_nettype wire

// File: rtl/cve2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : cve2_mem_responder
// Description : Memory-side responder for a req/gnt/rvalid port. Word array
//               with byte-enable writes, grant limited by an outstanding
//               counter and a stall input, in-order responses RespLatency
//               cycles after grant. Out-of-range accesses answer err=1.
//               Ports:
//                 clk_i, rst_i          clock, async active-high reset
//                 stall_i               suppresses grant while high
//                 req_i / gnt_o         request handshake
//                 addr_i, we_i, be_i,
//                 wdata_i               request payload (sampled at grant)
//                 rvalid_o, rdata_o,
//                 err_o                 response, one cycle per grant
// Revision    : 1.0 - initial release
// ============================================================================
module cve2_mem_responder
    import cve2_mem_resp_pkg::*;
#(
    parameter logic [31:0] AddrBase       = 32'h0000_0000,
    parameter int unsigned MemWords       = 1024,
    parameter int unsigned RespLatency    = 1,
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned c_CNT_W = $clog2(MaxOutstanding + 1);
    localparam int unsigned c_IDX_W = $clog2(MemWords);
    localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MaxOutstanding);

    logic [31:0]        r_mem [MemWords];
    logic [c_CNT_W-1:0] r_outstanding;

    mem_decode_t        w_dec;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_unused_idx;
    logic               w_accept;
    mem_resp_t          w_resp_in;
    mem_resp_t          w_resp_out;

    assign w_dec        = mem_decode(addr_i, AddrBase, 32'(MemWords));
    assign w_idx        = w_dec.word_idx[c_IDX_W-1:0];
    assign w_unused_idx = ^w_dec.word_idx[31:c_IDX_W];

    // No bypass: a response retiring this cycle does not free a slot until
    // the counter updates at the edge.
    assign gnt_o    = req_i & ~stall_i & (r_outstanding < c_MAX_OUT);
    assign w_accept = req_i & gnt_o;

    // Response is formed at the grant edge; the read sees the array before
    // this edge's write, which only matters for writes (rdata is 0 then).
    always_comb begin
        w_resp_in = '0;
        if (w_accept) begin
            w_resp_in.valid = 1'b1;
            w_resp_in.err   = ~w_dec.in_range;
            if (!we_i && w_dec.in_range) begin
                w_resp_in.rdata = r_mem[w_idx];
            end
        end
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && we_i && w_dec.in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (be_i[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else if (w_accept && !w_resp_out.valid) begin
            r_outstanding <= r_outstanding + c_CNT_W'(1);
        end else if (!w_accept && w_resp_out.valid) begin
            r_outstanding <= r_outstanding - c_CNT_W'(1);
        end
    end

    cve2_mem_resp_delay #(
        .Depth (RespLatency)
    ) u_delay (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .resp_i (w_resp_in),
        .resp_o (w_resp_out)
    );

    // Idle slots in the delay line are all-zero, so no output gating needed.
    assign rvalid_o = w_resp_out.valid;
    assign rdata_o  = w_resp_out.rdata;
    assign err_o    = w_resp_out.err;

    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (r_outstanding <= c_MAX_OUT)
                else $error("outstanding counter above limit");
            assert (!(w_resp_out.valid && (r_outstanding == '0)))
                else $error("response with no outstanding request");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cve2_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cve2_mem_responder
// Description : Directed self-checking bench. Instance A: latency 1, small
//               array at base 0x1000. Instance B: latency 3, two outstanding.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cve2_mem_responder;

    logic clk;
    logic rst;

    logic        a_stall, a_req, a_gnt, a_we, a_rvalid, a_err;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_be;

    logic        b_stall, b_req, b_gnt, b_we, b_rvalid, b_err;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_be;

    int n_vec;
    int n_miss;

    cve2_mem_responder #(
        .AddrBase       (32'h0000_1000),
        .MemWords       (16),
        .RespLatency    (1),
        .MaxOutstanding (2)
    ) u_dut_a (
        .clk_i    (clk),
        .rst_i    (rst),
        .stall_i  (a_stall),
        .req_i    (a_req),
        .gnt_o    (a_gnt),
        .addr_i   (a_addr),
        .we_i     (a_we),
        .be_i     (a_be),
        .wdata_i  (a_wdata),
        .rvalid_o (a_rvalid),
        .rdata_o  (a_rdata),
        .err_o    (a_err)
    );

    cve2_mem_responder #(
        .AddrBase       (32'h0000_0000),
        .MemWords       (16),
        .RespLatency    (3),
        .MaxOutstanding (2)
    ) u_dut_b (
        .clk_i    (clk),
        .rst_i    (rst),
        .stall_i  (b_stall),
        .req_i    (b_req),
        .gnt_o    (b_gnt),
        .addr_i   (b_addr),
        .we_i     (b_we),
        .be_i     (b_be),
        .wdata_i  (b_wdata),
        .rvalid_o (b_rvalid),
        .rdata_o  (b_rdata),
        .err_o    (b_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // Single request on A, latency 1: grant in the request cycle, response next cycle.
    task automatic a_txn(input string tag, input logic we, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_err);
        @(posedge clk); #1;
        a_req = 1'b1; a_we = we; a_addr = addr; a_be = be; a_wdata = wd;
        @(negedge clk);
        chk({tag, ".gnt"}, 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk({tag, ".rvalid"}, 32'(a_rvalid), 32'd1);
        chk({tag, ".rdata"}, a_rdata, exp_rd);
        chk({tag, ".err"}, 32'(a_err), 32'(exp_err));
    endtask

    // Six requests with req held on B (latency 3, limit 2). Hand-derived
    // grant/rvalid pattern per cycle; responses in issue order.
    task automatic b_burst(input logic we);
        bit exp_gnt [14] = '{1,1,0,0,1,1,0,0,1,1,0,0,0,0};
        bit exp_rv  [14] = '{0,0,0,1,1,0,0,1,1,0,0,1,1,0};
        int n = 0;
        int r = 0;
        for (int c = 0; c < 14; c++) begin
            @(posedge clk); #1;
            b_req   = (n < 6);
            b_we    = we;
            b_addr  = 32'(n * 4);
            b_be    = 4'hF;
            b_wdata = 32'hB000_0000 + 32'(n);
            @(negedge clk);
            chk($sformatf("b_burst%0d.c%0d.gnt", we, c), 32'(b_gnt), 32'(exp_gnt[c]));
            chk($sformatf("b_burst%0d.c%0d.rvalid", we, c), 32'(b_rvalid), 32'(exp_rv[c]));
            if (exp_rv[c]) begin
                chk($sformatf("b_burst%0d.r%0d.rdata", we, r), b_rdata,
                    we ? 32'h0 : (32'hB000_0000 + 32'(r)));
                chk($sformatf("b_burst%0d.r%0d.err", we, r), 32'(b_err), 32'd0);
                r++;
            end
            if (b_req && b_gnt) n++;
        end
        @(posedge clk); #1;
        b_req = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        rst = 1'b1;
        a_stall = 0; a_req = 0; a_we = 0; a_addr = 0; a_be = 0; a_wdata = 0;
        b_stall = 0; b_req = 0; b_we = 0; b_addr = 0; b_be = 0; b_wdata = 0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.a_rvalid", 32'(a_rvalid), 32'd0);
        chk("rst.a_rdata", a_rdata, 32'd0);
        chk("rst.a_err", 32'(a_err), 32'd0);
        chk("rst.b_rvalid", 32'(b_rvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst.a_rvalid", 32'(a_rvalid), 32'd0);
        chk("post_rst.b_rvalid", 32'(b_rvalid), 32'd0);

        // Full write then read back
        a_txn("wr_full", 1'b1, 32'h0000_1008, 4'hF, 32'hDEAD_BEEF, 32'h0, 1'b0);
        a_txn("rd_full", 1'b0, 32'h0000_1008, 4'h0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        @(negedge clk);
        chk("rd_full.rvalid_drop", 32'(a_rvalid), 32'd0);
        chk("rd_full.rdata_drop", a_rdata, 32'd0);

        // Partial write 0101 over AABBCCDD
        a_txn("wr_base", 1'b1, 32'h0000_100C, 4'hF, 32'hAABB_CCDD, 32'h0, 1'b0);
        a_txn("wr_part", 1'b1, 32'h0000_100C, 4'b0101, 32'h1122_3344, 32'h0, 1'b0);
        a_txn("rd_part", 1'b0, 32'h0000_100C, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0);

        // be=0 write: normal response, no change
        a_txn("wr_be0", 1'b1, 32'h0000_100C, 4'b0000, 32'hFFFF_FFFF, 32'h0, 1'b0);
        a_txn("rd_be0", 1'b0, 32'h0000_100C, 4'h0, 32'h0, 32'hAA22_CC44, 1'b0);

        // Range boundaries
        a_txn("wr_w0", 1'b1, 32'h0000_1000, 4'hF, 32'h0123_4567, 32'h0, 1'b0);
        a_txn("wr_last", 1'b1, 32'h0000_103C, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0);
        a_txn("rd_last", 1'b0, 32'h0000_103C, 4'h0, 32'h0, 32'hCAFE_F00D, 1'b0);
        a_txn("rd_oor_hi", 1'b0, 32'h0000_1040, 4'h0, 32'h0, 32'h0, 1'b1);
        a_txn("wr_oor_lo", 1'b1, 32'h0000_0FFC, 4'hF, 32'h5555_5555, 32'h0, 1'b1);
        a_txn("rd_w0", 1'b0, 32'h0000_1000, 4'h0, 32'h0, 32'h0123_4567, 1'b0);

        // Back-to-back reads on A (limit 2 >= latency+1)
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_1008;
        @(negedge clk);
        chk("b2b.g0", 32'(a_gnt), 32'd1);
        chk("b2b.rv0", 32'(a_rvalid), 32'd0);
        @(posedge clk); #1;
        a_addr = 32'h0000_100C;
        @(negedge clk);
        chk("b2b.g1", 32'(a_gnt), 32'd1);
        chk("b2b.d0", a_rdata, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        a_addr = 32'h0000_1000;
        @(negedge clk);
        chk("b2b.g2", 32'(a_gnt), 32'd1);
        chk("b2b.d1", a_rdata, 32'hAA22_CC44);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk("b2b.rv2", 32'(a_rvalid), 32'd1);
        chk("b2b.d2", a_rdata, 32'h0123_4567);
        @(negedge clk);
        chk("b2b.idle", 32'(a_rvalid), 32'd0);

        // Stall for 5 cycles with req held
        @(posedge clk); #1;
        a_req = 1'b1; a_we = 1'b0; a_addr = 32'h0000_1008; a_stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("stall.c%0d.gnt", i), 32'(a_gnt), 32'd0);
            chk($sformatf("stall.c%0d.rvalid", i), 32'(a_rvalid), 32'd0);
            @(posedge clk); #1;
        end
        a_stall = 1'b0;
        @(negedge clk);
        chk("stall.release.gnt", 32'(a_gnt), 32'd1);
        @(posedge clk); #1;
        a_req = 1'b0;
        @(negedge clk);
        chk("stall.resp.rvalid", 32'(a_rvalid), 32'd1);
        chk("stall.resp.rdata", a_rdata, 32'hDEAD_BEEF);

        // Latency 3 / limit 2: writes then reads of words 0..5
        b_burst(1'b1);
        b_burst(1'b0);

        // Reset one cycle after a read grant drops the response
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h4;
        @(negedge clk);
        chk("rstmid.gnt", 32'(b_gnt), 32'd1);
        @(posedge clk); #1;
        b_req = 1'b0; rst = 1'b1;
        @(negedge clk);
        chk("rstmid.in_rst.rvalid", 32'(b_rvalid), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("rstmid.after%0d.rvalid", i), 32'(b_rvalid), 32'd0);
        end
        @(posedge clk); #1;
        b_req = 1'b1; b_we = 1'b0; b_addr = 32'h8;
        @(negedge clk);
        chk("rstmid.next.gnt", 32'(b_gnt), 32'd1);
        @(posedge clk); #1;
        b_req = 1'b0;
        @(negedge clk);
        chk("rstmid.next.rv1", 32'(b_rvalid), 32'd0);
        @(negedge clk);
        chk("rstmid.next.rv2", 32'(b_rvalid), 32'd0);
        @(negedge clk);
        chk("rstmid.next.rv3", 32'(b_rvalid), 32'd1);
        chk("rstmid.next.rdata", b_rdata, 32'hB000_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cve2_mem_responder.md
Name: cve2_mem_responder

Overview:
- Memory-side responder for the core's instruction or data request/grant/rvalid interface; one instance serves one port.
- Contains a word-organised storage array, grants requests subject to an outstanding limit and an external stall input, applies writes with byte enables, and returns in-order responses a fixed number of cycles after grant.
- Used as the simulation and FPGA memory model behind the core top level.

Parameters:
- AddrBase, 32'h0000_0000, byte address of word 0; must be 4-byte aligned.
- MemWords, 1024, depth in 32-bit words; must be at least 2.
- RespLatency, 1, cycles from grant to rvalid; must be at least 1.
- MaxOutstanding, 2, maximum granted-but-unanswered requests; must be at least 1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- stall_i  in  1  suppresses gnt_o while high (bench back-pressure)
- req_i  in  1  request valid
- gnt_o  out  1  request accepted this cycle
- addr_i  in  32  byte address; bits [1:0] ignored
- we_i  in  1  1 = write, 0 = read
- be_i  in  4  byte enables for writes; ignored for reads
- wdata_i  in  32  write data
- rvalid_o  out  1  response valid, one cycle per granted request
- rdata_o  out  32  read data; 0 for writes and errors
- err_o  out  1  response error, qualified by rvalid_o

Behaviour:
- Reset:
  - rvalid_o=0, rdata_o=0, err_o=0.
  - Outstanding counter is 0; delay pipeline is cleared.
  - Storage contents are not reset.
  - Assertion mid-operation drops all in-flight responses; no late rvalid after release.
- Grant:
  - gnt_o = req_i & ~stall_i & (outstanding_q < MaxOutstanding). Combinational, no bypass on a same-cycle rvalid.
  - The request is accepted at the clock edge where req_i & gnt_o.
  - Payload is sampled only then; the requester holds it while req_i is high and not granted.
- Address decode:
  - offset = addr_i - AddrBase, 32-bit unsigned wrap.
  - in_range = offset < 4*MemWords; word index = offset >> 2.
  - Address below AddrBase wraps to a large offset and is therefore out of range.
- Accepted write, in range:
  - At the grant edge, byte k of the word is updated when be_i[k]=1.
  - be_i=4'b0000 changes nothing and still produces a normal response.
- Accepted read, in range:
  - Word is read at the grant edge and reflects every earlier-accepted write.
- Out of range:
  - Storage is untouched; the response carries err=1 and rdata=0.
- Response timing:
  - Grant at cycle t gives rvalid_o=1 for exactly one cycle at t+RespLatency, with that request's rdata and err.
  - At most one grant per cycle, so responses are strictly in order and never collide; back-to-back grants give back-to-back rvalids.
- Outstanding counter:
  - +1 on grant, -1 on rvalid_o, unchanged when both occur in the same cycle.
  - Width is $clog2(MaxOutstanding+1).
  - Never exceeds MaxOutstanding and never underflows; assertions cover both.
- Throughput:
  - Back-to-back grants when MaxOutstanding >= RespLatency+1.
  - Otherwise grants stall until a response retires.
- Output registers:
  - Outputs are driven from the final pipeline stage. When not valid, rdata_o and err_o are 0 (no stale data).

Decomposition:
- Shared package cve2_mem_resp_pkg:
  - typedef mem_resp_t {logic valid; logic err; logic [31:0] rdata;}.
  - Function for the in_range/index decode.
- Sub-module cve2_mem_resp_delay: RespLatency-deep shift register of mem_resp_t with asynchronous active-high clear.
- Storage array, grant logic and outstanding counter stay in the top.

Test Plan:
- Reset, then write 0xDEADBEEF to AddrBase+8 with be=4'hF, then read it (latency 1) -> gnt in the request cycle; write response rvalid=1, rdata=0, err=0; read rvalid one cycle after its grant with rdata=0xDEADBEEF.
- Partial write be=4'b0101, wdata=0x11223344 over a word holding 0xAABBCCDD, then read -> 0xAA22CC44.
- Read of AddrBase+4*MemWords and write to AddrBase-4 -> both respond err=1, rdata=0; a subsequent read of word 0 is unchanged.
- RespLatency=3, MaxOutstanding=2, req held high for 6 requests -> pattern gnt,gnt,stall,stall,gnt,...; outstanding never exceeds 2; responses in issue order at t+3.
- stall_i high for 5 cycles with req_i high -> gnt_o=0 throughout, no rvalid; the grant follows on the cycle stall_i drops.
- rst_i asserted one cycle after a read grant with RespLatency=3 -> rvalid_o never asserts for that read; after release the outstanding count is 0 and the next request is granted immediately.
